calc_mem_ctrl: RTL and testbench
================================

# calc_mem_ctrl

Sequencer that sits directly upstream of the calculator's single-port synchronous operand RAM. On a start command it reads operand A and operand B from RAM, executes one signed 16-bit operation, and writes the result back to a third address. It drives the RAM's address, chip-select, write-enable and output-enable, and owns the shared tristate data bus whenever it writes.

## Interface
- ADDR_WIDTH, 4, RAM address width (RAM depth 2**ADDR_WIDTH)
- DATA_WIDTH, 16, operand/result width, two's-complement signed
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  command strobe; sampled only in IDLE
- op  in  3  operation code (see package)
- addr_a, addr_b, addr_r  in  ADDR_WIDTH each  operand A, operand B, result addresses
- busy  out  1  high from the cycle after start is accepted through WR
- done  out  1  one-cycle pulse, command complete
- result  out  DATA_WIDTH  last written result, held until next done
- ovf  out  1  signed overflow of last command, held until next done
- err  out  1  reserved op in last command, held until next done
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_data  inout  DATA_WIDTH  RAM data bus; driven only in WR, else high-Z
- mem_cs, mem_we, mem_oe  out  1 each  RAM chip-select, write-enable, output-enable

## Operation
- FSM states: IDLE, RD_A, CAP_A, RD_B, CAP_B, EXEC, WR, DONE.
- IDLE: start=1 latches op and all three addresses; next RD_A. start=0 stays in IDLE.
- RD_A: mem_addr=addr_a, cs=1, we=0, oe=0 (RAM registers read data) -> CAP_A.
- CAP_A: same address, cs=1, we=0, oe=1; A captured from mem_data at end of cycle -> RD_B.
- RD_B / CAP_B: identical to RD_A / CAP_A with addr_b -> EXEC.
- EXEC: cs=0; ALU result, ovf and err registered -> WR.
- WR: mem_addr=addr_r, cs=1, we=1, oe=0, mem_data driven with result -> DONE.
- DONE: all memory controls 0, done=1, result/ovf/err updated -> IDLE.
- Ops: 000 ADD, 001 SUB, 010 MUL (low 16 bits of signed product), 011 AND, 100 OR, 101 XOR, 110 SLT (1 if A<B signed, else 0), 111 reserved (result 0, err=1).
- ovf: ADD/SUB when operand signs make the true result exceed [-32768, 32767]; MUL when the 32-bit product does not sign-extend from bit 15; 0 for all other ops.
- start while not IDLE: ignored, not queued.
- addr_r equal to addr_a or addr_b: legal; both reads complete before the write.
- mem_oe and the controller's bus driver are never active in the same cycle.

## Timing
- Memory controls, busy and done decode from the state register only (Moore); no combinational path from start.
- Start sampled high at edge E -> RD_A in the cycle after E; done high exactly 7 cycles after the start cycle; next start accepted in the cycle after done.
- RAM write lands at the rising edge ending WR; a read of addr_r issued from the following command returns the new value.
- Reset (rst_n=0 at an edge): state IDLE; mem_cs=mem_we=mem_oe=0, mem_addr=0, mem_data high-Z, busy=0, done=0, result=0, ovf=0, err=0.
- Reset mid-operation: command aborted; if asserted during WR the write at that edge still completes (RAM sampled the same edge), no later memory access occurs, no done pulse.

## Structure
- calc_pkg: op_t enum (values above), state_t enum, DATA_WIDTH default constant.
- Sub-module calc_alu: purely combinational, inputs A, B, op; outputs result, ovf, err. Controller instantiates it and registers its outputs in EXEC.
- Tristate on mem_data lives in calc_mem_ctrl only, enabled solely by state==WR.

## Test plan
- RAM[1]=5, RAM[2]=7, ADD a=1 b=2 r=3 -> done 7 cycles after start, RAM[3]=12, result=12, ovf=0.
- RAM[1]=32767, RAM[2]=1, ADD -> RAM[r]=-32768, ovf=1; SUB -32768-1 -> 32767, ovf=1.
- MUL 300*200 -> RAM[r]=0xEA60 low bits, ovf=1; MUL -3*4 -> -12, ovf=0; SLT -1,1 -> 1.
- addr_r=addr_a=4, RAM[4]=9, RAM[5]=2, SUB -> RAM[4]=7; start pulsed while busy -> ignored, single done.
- op=111 -> RAM[r]=0, err=1; following valid command clears err on its done.
- rst_n low during CAP_B -> next cycle all outputs at reset values, mem_data high-Z, no write to addr_r, no done; bus checker confirms mem_oe and driver never overlap throughout.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types for the calculator memory sequencer: operation codes,
// controller states and the default operand width.
package calc_pkg;

  localparam int unsigned DATA_WIDTH = 16;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SLT = 3'b110,
    OP_RSV = 3'b111
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_CAP_A,
    S_RD_B,
    S_CAP_B,
    S_EXEC,
    S_WR,
    S_DONE
  } state_t;

endpackage

// File: rtl/calc_alu.sv
// Combinational signed ALU: one operation on two two's-complement operands,
// with signed-overflow and reserved-op flags.
module calc_alu #(
  parameter int unsigned W = calc_pkg::DATA_WIDTH
) (
  input  logic [W-1:0]     i_a,
  input  logic [W-1:0]     i_b,
  input  calc_pkg::op_t    i_op,
  output logic [W-1:0]     o_result,
  output logic             o_ovf,
  output logic             o_err
);
  import calc_pkg::*;

  logic [W-1:0]          w_sum;
  logic [W-1:0]          w_diff;
  logic signed [2*W-1:0] w_prod;
  logic [W:0]            w_prod_hi;
  logic                  w_slt;

  assign w_sum     = i_a + i_b;
  assign w_diff    = i_a - i_b;
  assign w_prod    = $signed(i_a) * $signed(i_b);
  // Product fits in W bits only if its upper W+1 bits are a pure sign extension.
  assign w_prod_hi = w_prod[2*W-1:W-1];
  assign w_slt     = ($signed(i_a) < $signed(i_b));

  // Select result and flags for the requested operation.
  always_comb begin
    o_result = '0;
    o_ovf    = 1'b0;
    o_err    = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_result = w_sum;
        o_ovf    = (i_a[W-1] == i_b[W-1]) && (w_sum[W-1] != i_a[W-1]);
      end
      OP_SUB: begin
        o_result = w_diff;
        o_ovf    = (i_a[W-1] != i_b[W-1]) && (w_diff[W-1] != i_a[W-1]);
      end
      OP_MUL: begin
        o_result = w_prod[W-1:0];
        o_ovf    = !((w_prod_hi == '0) || (w_prod_hi == '1));
      end
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_SLT:  o_result = {{(W-1){1'b0}}, w_slt};
      default: o_err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/calc_mem_ctrl.sv
// Sequencer in front of the single-port synchronous operand RAM: reads A and B,
// runs one ALU operation and writes the result back, owning the data bus in WR.
module calc_mem_ctrl #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = calc_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [ADDR_WIDTH-1:0] addr_r,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  ovf,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe
);
  import calc_pkg::*;

  state_t                r_state;
  state_t                w_next;
  op_t                   r_op;
  logic [ADDR_WIDTH-1:0] r_addr_a;
  logic [ADDR_WIDTH-1:0] r_addr_b;
  logic [ADDR_WIDTH-1:0] r_addr_r;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_alu_res;
  logic                  r_alu_ovf;
  logic                  r_alu_err;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_ovf;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] w_alu_res;
  logic                  w_alu_ovf;
  logic                  w_alu_err;
  logic                  w_drive;

  calc_alu #(.W(DATA_WIDTH)) u_alu (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_op     (r_op),
    .o_result (w_alu_res),
    .o_ovf    (w_alu_ovf),
    .o_err    (w_alu_err)
  );

  // Bus driver is tied to the write state alone, so it can never overlap mem_oe.
  assign w_drive  = (r_state == S_WR);
  assign mem_data = w_drive ? r_alu_res : 'z;

  assign result = r_result;
  assign ovf    = r_ovf;
  assign err    = r_err;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: fixed walk through the sequence once a start is accepted.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RD_A;
      S_RD_A:  w_next = S_CAP_A;
      S_CAP_A: w_next = S_RD_B;
      S_RD_B:  w_next = S_CAP_B;
      S_CAP_B: w_next = S_EXEC;
      S_EXEC:  w_next = S_WR;
      S_WR:    w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Moore outputs: memory controls, busy and done from the state register only.
  always_comb begin
    mem_addr = '0;
    mem_cs   = 1'b0;
    mem_we   = 1'b0;
    mem_oe   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_RD_A:  begin mem_addr = r_addr_a; mem_cs = 1'b1; busy = 1'b1; end
      S_CAP_A: begin mem_addr = r_addr_a; mem_cs = 1'b1; mem_oe = 1'b1; busy = 1'b1; end
      S_RD_B:  begin mem_addr = r_addr_b; mem_cs = 1'b1; busy = 1'b1; end
      S_CAP_B: begin mem_addr = r_addr_b; mem_cs = 1'b1; mem_oe = 1'b1; busy = 1'b1; end
      S_EXEC:  busy = 1'b1;
      S_WR:    begin mem_addr = r_addr_r; mem_cs = 1'b1; mem_we = 1'b1; busy = 1'b1; end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: latch command, capture operands, register ALU output, publish status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op      <= OP_ADD;
      r_addr_a  <= '0;
      r_addr_b  <= '0;
      r_addr_r  <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_alu_res <= '0;
      r_alu_ovf <= 1'b0;
      r_alu_err <= 1'b0;
      r_result  <= '0;
      r_ovf     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_op     <= op_t'(op);
          r_addr_a <= addr_a;
          r_addr_b <= addr_b;
          r_addr_r <= addr_r;
        end
        S_CAP_A: r_a <= mem_data;
        S_CAP_B: r_b <= mem_data;
        S_EXEC: begin
          r_alu_res <= w_alu_res;
          r_alu_ovf <= w_alu_ovf;
          r_alu_err <= w_alu_err;
        end
        S_WR: begin
          r_result <= r_alu_res;
          r_ovf    <= r_alu_ovf;
          r_err    <= r_alu_err;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_mem_ctrl.sv
// Scoreboard bench for calc_mem_ctrl with a behavioural synchronous RAM and an
// arithmetic reference model of each command.
module tb_calc_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [3:0]  addr_a, addr_b, addr_r;
  logic        busy, done, ovf, err;
  logic [15:0] result;
  logic [3:0]  mem_addr;
  wire  [15:0] mem_data;
  logic        mem_cs, mem_we, mem_oe;

  always #5 clk = ~clk;

  calc_mem_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .addr_a(addr_a), .addr_b(addr_b), .addr_r(addr_r),
    .busy(busy), .done(done), .result(result), .ovf(ovf), .err(err),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe)
  );

  // Synchronous single-port RAM with registered read data and a backdoor write port.
  logic [15:0] ram [16];
  logic [15:0] ram_q;
  logic        bd_we;
  logic [3:0]  bd_addr;
  logic [15:0] bd_data;

  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (mem_cs && mem_we) ram[mem_addr] <= mem_data;
    if (mem_cs && !mem_we) ram_q <= ram[mem_addr];
  end
  assign mem_data = (mem_cs && mem_oe && !mem_we) ? ram_q : 'z;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    logic        err;
    logic [3:0]  addr_r;
    int          done_cyc;
  } exp_t;

  exp_t        q[$];
  logic [15:0] ref_mem [16];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: exact integer arithmetic, result range-checked against 16-bit signed.
  function automatic void model(input logic [2:0] o, input logic [15:0] au, input logic [15:0] bu,
                                output logic [15:0] res, output logic v, output logic e);
    longint a, b, t;
    a = longint'($signed(au));
    b = longint'($signed(bu));
    t = 0;
    v = 1'b0;
    e = 1'b0;
    case (o)
      3'd0: t = a + b;
      3'd1: t = a - b;
      3'd2: t = a * b;
      3'd3: t = a & b;
      3'd4: t = a | b;
      3'd5: t = a ^ b;
      3'd6: t = (a < b) ? 1 : 0;
      default: begin t = 0; e = 1'b1; end
    endcase
    if (o <= 3'd2) v = (t > 32767) || (t < -32768);
    res = t[15:0];
  endfunction

  // Monitor: pops an expectation on every done pulse; also watches the bus each cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) chk("bus_oe_vs_write", {31'd0, mem_oe & mem_we}, 32'd0);
    if (done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending command (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("done_latency", cyc, e.done_cyc);
        chk("result", {16'd0, result}, {16'd0, e.res});
        chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
        chk("err", {31'd0, err}, {31'd0, e.err});
        chk("ram_written", {16'd0, ram[e.addr_r]}, {16'd0, e.res});
        chk("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic poke(input logic [3:0] a, input logic [15:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic check_reset_outputs();
    chk("rst_cs", {31'd0, mem_cs}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_oe", {31'd0, mem_oe}, 32'd0);
    chk("rst_addr", {28'd0, mem_addr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
  endtask

  // Issue one command from an idle negedge; optionally pulse a stray start at cycle ign_at.
  task automatic run_cmd(input logic [2:0] o, input logic [3:0] aa, input logic [3:0] ab,
                         input logic [3:0] ar, input int ign_at);
    exp_t        e;
    logic [15:0] r;
    logic        v, er;
    model(o, ref_mem[aa], ref_mem[ab], r, v, er);
    ref_mem[ar] = r;
    e.res = r; e.ovf = v; e.err = er; e.addr_r = ar; e.done_cyc = cyc + 7;
    q.push_back(e);
    start = 1'b1; op = o; addr_a = aa; addr_b = ab; addr_r = ar;
    @(negedge clk);
    start = 1'b0;
    op = 3'($urandom); addr_a = 4'($urandom); addr_b = 4'($urandom); addr_r = 4'($urandom);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    for (int k = 1; k < 20 && !done; k++) begin
      start = (k == ign_at);
      @(negedge clk);
    end
    start = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got done=0 expected done within 20 cycles");
    end
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] ra, rb, rr;
    rst_n = 1'b0; start = 1'b0; op = '0;
    addr_a = '0; addr_b = '0; addr_r = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 16; i++) poke(4'(i), 16'($urandom));

    poke(4'd1, 16'd5);     poke(4'd2, 16'd7);  run_cmd(3'd0, 4'd1, 4'd2, 4'd3, 0);
    poke(4'd1, 16'h7FFF);  poke(4'd2, 16'd1);  run_cmd(3'd0, 4'd1, 4'd2, 4'd6, 0);
    poke(4'd7, 16'h8000);  poke(4'd8, 16'd1);  run_cmd(3'd1, 4'd7, 4'd8, 4'd9, 0);
    poke(4'd1, 16'd300);   poke(4'd2, 16'd200); run_cmd(3'd2, 4'd1, 4'd2, 4'd3, 0);
    poke(4'd1, 16'hFFFD);  poke(4'd2, 16'd4);  run_cmd(3'd2, 4'd1, 4'd2, 4'd3, 0);
    poke(4'd1, 16'hFFFF);  poke(4'd2, 16'd1);  run_cmd(3'd6, 4'd1, 4'd2, 4'd3, 0);
    poke(4'd4, 16'd9);     poke(4'd5, 16'd2);  run_cmd(3'd1, 4'd4, 4'd5, 4'd4, 3);
    repeat (10) @(negedge clk);
    run_cmd(3'd7, 4'd1, 4'd2, 4'd10, 0);
    run_cmd(3'd0, 4'd4, 4'd5, 4'd11, 0);

    // Abort during CAP_B: no write, no done, outputs back to reset values.
    poke(4'd12, 16'h5555);
    start = 1'b1; op = 3'd0; addr_a = 4'd4; addr_b = 4'd5; addr_r = 4'd12;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_no_write", {16'd0, ram[12]}, {16'd0, ref_mem[12]});

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) poke(4'($urandom), 16'($urandom));
      ra = 4'($urandom); rb = 4'($urandom);
      rr = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom);
      run_cmd(3'($urandom), ra, rb, rr, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0);
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
